// File: rtl/fsm_counter_param_pkg.sv
// -----------------------------------------------------------------------------
// fsm_counter_param_pkg
// Shared constants for the parameterised tick-driven counter FSM.
//   - state_t : FSM state encodings (IDLE/RUN/PAUSED; encoding 3 is illegal
//               and recovers to IDLE)
//   - mode_t  : count-mode encodings, as presented on the 2-bit mode input
//   - is_busy : true for the states that the busy output reports
// -----------------------------------------------------------------------------
package fsm_counter_param_pkg;

    localparam int STATE_W = 2;
    localparam int MODE_W  = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    typedef enum logic [MODE_W-1:0] {
        MODE_UP_ONESHOT   = 2'd0,
        MODE_UP_RELOAD    = 2'd1,
        MODE_DOWN_ONESHOT = 2'd2,
        MODE_BOUNCE       = 2'd3
    } mode_t;

    function automatic logic is_busy(input state_t s);
        return (s == ST_RUN) || (s == ST_PAUSED);
    endfunction

endpackage : fsm_counter_param_pkg

// File: rtl/fsm_counter_param_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Free-running clock divider producing a one-cycle tick every CLK_DIV enabled
// clk cycles.
//   clk  : system clock
//   rst  : asynchronous active-high reset (divider to 0)
//   clr  : synchronous clear of the divider (takes precedence over en)
//   en   : advance the divider this cycle; when low the divider is frozen
//   tick : high during the last enabled cycle of each CLK_DIV period
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int CLK_DIV = 1500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;

    // The tick is combinational so the consumer acts on it in the same cycle
    // the divider wraps; gating by en keeps a frozen divider from ticking.
    assign tick = en && (div_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else if (clr) begin
            div_q <= '0;
        end else if (en) begin
            if (div_q == LAST) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

endmodule : tick_gen

// File: rtl/fsm_counter_param.sv
// -----------------------------------------------------------------------------
// fsm_counter_param
// Tick-driven counter controlled by a three-state FSM (IDLE/RUN/PAUSED).
// Four count modes: up one-shot, up auto-reload, down one-shot and bounce
// (up to MAX_COUNT then back down to 0). Input priority each cycle is
// stop > go > pause > tick.
//
// Parameters
//   CNT_W     : count width in bits
//   CLK_DIV   : clk cycles per count tick (>= 2)
//   MAX_COUNT : terminal count value (1 .. 2**CNT_W-1)
// Ports
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   go    : single-cycle start/restart pulse (mode is sampled here)
//   stop  : single-cycle abort pulse (count -> 0, no done)
//   pause : level hold request; freezes the tick divider
//   mode  : 0 up one-shot, 1 up auto-reload, 2 down one-shot, 3 bounce
//   count : current count value
//   done  : registered one-cycle completion / wrap pulse
//   busy  : high in RUN or PAUSED
//   state : current FSM state encoding
// -----------------------------------------------------------------------------
module fsm_counter_param
    import fsm_counter_param_pkg::*;
#(
    parameter int CNT_W     = 4,
    parameter int CLK_DIV   = 1500000,
    parameter int MAX_COUNT = 2**CNT_W - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             stop,
    input  logic             pause,
    input  logic [1:0]       mode,
    output logic [CNT_W-1:0] count,
    output logic             done,
    output logic             busy,
    output logic [1:0]       state
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

    state_t           state_q, state_n;
    mode_t            mode_q, mode_n;
    logic [CNT_W-1:0] count_q, count_n;
    logic             dir_down_q, dir_down_n;
    logic             done_q, done_n;

    logic             busy_int;
    logic             div_clr;
    logic             div_en;
    logic             tick;

    // Saturating step helpers: count never leaves 0..MAX_COUNT even if the
    // caller forgets to test the terminal value first.
    function automatic logic [CNT_W-1:0] count_inc(input logic [CNT_W-1:0] c);
        return (c >= MAX_C) ? MAX_C : c + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] count_dec(input logic [CNT_W-1:0] c);
        return (c == '0) ? '0 : c - 1'b1;
    endfunction

    assign busy_int = is_busy(state_q);

    // The divider is held at 0 outside RUN/PAUSED and restarted by go/stop.
    // It only advances while busy with pause low, so a tick can never land
    // in a cycle where pause is being asserted, and a paused divider resumes
    // exactly where it stopped.
    assign div_clr = go | stop | ~busy_int;
    assign div_en  = busy_int & ~pause;

    tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (div_clr),
        .en   (div_en),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_UP_ONESHOT;
            count_q    <= '0;
            dir_down_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_n;
            mode_q     <= mode_n;
            count_q    <= count_n;
            dir_down_q <= dir_down_n;
            done_q     <= done_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        mode_n     = mode_q;
        count_n    = count_q;
        dir_down_n = dir_down_q;
        done_n     = 1'b0;

        if (stop) begin
            state_n    = ST_IDLE;
            count_n    = '0;
            dir_down_n = 1'b0;
        end else if (go) begin
            state_n    = ST_RUN;
            mode_n     = mode_t'(mode);
            dir_down_n = 1'b0;
            count_n    = (mode_t'(mode) == MODE_DOWN_ONESHOT) ? MAX_C : '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // count holds its last value until go or stop
                end
                ST_RUN, ST_PAUSED: begin
                    if (pause) begin
                        state_n = ST_PAUSED;
                    end else begin
                        state_n = ST_RUN;
                        if (tick) begin
                            case (mode_q)
                                MODE_UP_ONESHOT: begin
                                    if (count_q == MAX_C) begin
                                        done_n  = 1'b1;
                                        state_n = ST_IDLE;
                                    end else begin
                                        count_n = count_inc(count_q);
                                    end
                                end
                                MODE_UP_RELOAD: begin
                                    if (count_q == MAX_C) begin
                                        done_n  = 1'b1;
                                        count_n = '0;
                                    end else begin
                                        count_n = count_inc(count_q);
                                    end
                                end
                                MODE_DOWN_ONESHOT: begin
                                    if (count_q == '0) begin
                                        done_n  = 1'b1;
                                        state_n = ST_IDLE;
                                    end else begin
                                        count_n = count_dec(count_q);
                                    end
                                end
                                MODE_BOUNCE: begin
                                    if (!dir_down_q) begin
                                        // Turn-around tick steps straight to
                                        // MAX_COUNT-1 so the peak is shown once.
                                        if (count_q == MAX_C) begin
                                            dir_down_n = 1'b1;
                                            count_n    = count_dec(count_q);
                                        end else begin
                                            count_n = count_inc(count_q);
                                        end
                                    end else if (count_q == '0) begin
                                        done_n     = 1'b1;
                                        state_n    = ST_IDLE;
                                        dir_down_n = 1'b0;
                                    end else begin
                                        count_n = count_dec(count_q);
                                    end
                                end
                                default: begin
                                    state_n = ST_IDLE;
                                end
                            endcase
                        end
                    end
                end
                default: begin
                    // Illegal encoding recovers to IDLE.
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    assign count = count_q;
    assign done  = done_q;
    assign busy  = busy_int;
    assign state = state_q;

endmodule : fsm_counter_param

// File: tb/tb_fsm_counter_param.sv
module tb_fsm_counter_param;

    localparam int CNT_W     = 4;
    localparam int CLK_DIV   = 4;
    localparam int MAX_COUNT = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             go;
    logic             stop;
    logic             pause;
    logic [1:0]       mode;
    logic [CNT_W-1:0] count;
    logic             done;
    logic             busy;
    logic [1:0]       state;

    fsm_counter_param #(
        .CNT_W     (CNT_W),
        .CLK_DIV   (CLK_DIV),
        .MAX_COUNT (MAX_COUNT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .go    (go),
        .stop  (stop),
        .pause (pause),
        .mode  (mode),
        .count (count),
        .done  (done),
        .busy  (busy),
        .state (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: tracks ticks since go and derives count from it.
    int m_state;    // 0 idle, 1 run, 2 paused
    int m_mode;
    int m_count;
    int m_ticks;    // ticks consumed since the last go
    int m_run;      // running (unfrozen) cycles since the last restart
    int m_done;

    int cyc;
    int done_cnt;
    int done_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_state = 0; m_mode = 0; m_count = 0; m_ticks = 0; m_run = 0; m_done = 0;
    endfunction

    function automatic void model_edge(input bit g, input bit s, input bit p, input int md);
        bit busy_now;
        bit tick;
        busy_now = (m_state != 0);
        tick     = busy_now && !p && !s && !g && ((m_run % CLK_DIV) == CLK_DIV - 1);
        m_done   = 0;
        if (s) begin
            m_state = 0; m_count = 0; m_run = 0;
        end else if (g) begin
            m_state = 1; m_mode = md; m_ticks = 0; m_run = 0;
            m_count = (md == 2) ? MAX_COUNT : 0;
        end else if (busy_now && p) begin
            m_state = 2;
        end else if (busy_now) begin
            m_state = 1;
            m_run++;
            if (tick) begin
                case (m_mode)
                    0: if (m_ticks == MAX_COUNT) begin m_done = 1; m_state = 0; end
                       else begin m_ticks++; m_count = m_ticks; end
                    1: begin
                        m_ticks++;
                        m_count = m_ticks % (MAX_COUNT + 1);
                        if (m_count == 0) m_done = 1;
                    end
                    2: if (m_ticks == MAX_COUNT) begin m_done = 1; m_state = 0; end
                       else begin m_ticks++; m_count = MAX_COUNT - m_ticks; end
                    default: if (m_ticks == 2 * MAX_COUNT) begin m_done = 1; m_state = 0; end
                       else begin
                           m_ticks++;
                           m_count = (m_ticks <= MAX_COUNT) ? m_ticks : 2 * MAX_COUNT - m_ticks;
                       end
                endcase
            end
        end
    endfunction

    task automatic cycle(input bit g, input bit s, input bit p, input logic [1:0] md);
        go = g; stop = s; pause = p; mode = md;
        @(posedge clk);
        model_edge(g, s, p, int'(md));
        #1;
        cyc++;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        check("count", 32'(count), 32'(m_count));
        check("done",  32'(done),  32'(m_done));
        check("state", 32'(state), 32'(m_state));
        check("busy",  32'(busy),  32'(m_state != 0));
        go = 1'b0; stop = 1'b0;
    endtask

    task automatic start(input logic [1:0] md);
        cyc = 0; done_cnt = 0; done_cyc = -1;
        cycle(1'b1, 1'b0, 1'b0, md);
    endtask

    initial begin
        logic [CNT_W-1:0] c5, c61, c41, c42;
        bit p_lvl;

        rst = 1'b1; go = 1'b0; stop = 1'b0; pause = 1'b0; mode = 2'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(count), 0);
        check("rst_done",  32'(done),  0);
        check("rst_busy",  32'(busy),  0);
        check("rst_state", 32'(state), 0);
        @(negedge clk);
        rst = 1'b0;

        // Mode 0 one-shot timing
        start(2'd0);
        c5 = '0; c61 = '0;
        for (int i = 2; i <= 80; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 2'd0);
            if (cyc == 5)  c5  = count;
            if (cyc == 61) c61 = count;
        end
        check("m0_count_at5",  32'(c5),  1);
        check("m0_count_at61", 32'(c61), 15);
        check("m0_done_cyc",   32'(done_cyc), 65);
        check("m0_done_cnt",   32'(done_cnt), 1);
        check("m0_end_state",  32'(state), 0);
        check("m0_end_count",  32'(count), 15);

        // Mode 1 auto-reload
        start(2'd1);
        repeat (69) cycle(1'b0, 1'b0, 1'b0, 2'd1);
        check("m1_done_cnt", 32'(done_cnt), 1);
        check("m1_done_cyc", 32'(done_cyc), 65);
        check("m1_state",    32'(state), 1);
        check("m1_busy",     32'(busy), 1);

        // Mode 2 down one-shot
        start(2'd2);
        check("m2_load", 32'(count), 15);
        repeat (70) cycle(1'b0, 1'b0, 1'b0, 2'd2);
        check("m2_done_cyc", 32'(done_cyc), 65);
        check("m2_end_count", 32'(count), 0);

        // Mode 3 bounce
        start(2'd3);
        repeat (130) cycle(1'b0, 1'b0, 1'b0, 2'd3);
        check("m3_done_cnt", 32'(done_cnt), 1);
        check("m3_done_cyc", 32'(done_cyc), 125);
        check("m3_state",    32'(state), 0);
        check("m3_count",    32'(count), 0);

        // Pause for 10 cycles at count 5
        start(2'd0);
        repeat (20) cycle(1'b0, 1'b0, 1'b0, 2'd0);
        repeat (10) cycle(1'b0, 1'b0, 1'b1, 2'd0);
        check("pause_count", 32'(count), 5);
        check("pause_state", 32'(state), 2);
        repeat (60) cycle(1'b0, 1'b0, 1'b0, 2'd0);
        check("pause_done_cyc", 32'(done_cyc), 75);
        check("pause_done_cnt", 32'(done_cnt), 1);

        // go and stop together during RUN
        start(2'd1);
        repeat (10) cycle(1'b0, 1'b0, 1'b0, 2'd1);
        cycle(1'b1, 1'b1, 1'b0, 2'd1);
        check("gostop_state", 32'(state), 0);
        check("gostop_count", 32'(count), 0);
        check("gostop_done",  32'(done), 0);

        // Asynchronous reset mid-RUN
        start(2'd0);
        repeat (10) cycle(1'b0, 1'b0, 1'b0, 2'd0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", 32'(count), 0);
        check("arst_done",  32'(done),  0);
        check("arst_busy",  32'(busy),  0);
        check("arst_state", 32'(state), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Restart at count 9
        start(2'd0);
        c41 = '1; c42 = '0;
        for (int i = 2; i <= 37; i++) cycle(1'b0, 1'b0, 1'b0, 2'd0);
        check("rs_count9", 32'(count), 9);
        cycle(1'b1, 1'b0, 1'b0, 2'd0);
        check("rs_count0", 32'(count), 0);
        for (int i = 39; i <= 42; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 2'd0);
            if (cyc == 41) c41 = count;
            if (cyc == 42) c42 = count;
        end
        check("rs_hold", 32'(c41), 0);
        check("rs_inc",  32'(c42), 1);

        // Randomized traffic against the model
        p_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 6) p_lvl = ~p_lvl;
            cycle($urandom_range(99) < 3, $urandom_range(199) < 1, p_lvl,
                  2'($urandom_range(3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fsm_counter_param
